prn_phase_ctrl: RTL and testbench

- Phase-selection controller for the PRN-based CDR. Sits after the bank of sampling flip-flops, which provides one sampled bit per phase per clk.
- Sweeps every sampling phase and checks each one against a local PRBS7 reference. Counts bit errors over a fixed window, then selects the phase with the fewest errors.
- Keeps monitoring the selected phase after lock and re-sweeps when lock is lost.

---
 rtl/prn_cdr_pkg.sv | 26 ++
 rtl/prbs7_chk.sv | 34 +++
 rtl/prn_phase_ctrl.sv | 179 +++++++++++++++++
 tb/tb_prn_phase_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prn_cdr_pkg.sv
// Shared definitions for the PRN-based CDR phase controller: FSM states,
// PRBS7 tap positions and the reference seeding length.
package prn_cdr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SEED       = 3'd1,
    ST_MEASURE    = 3'd2,
    ST_EVAL       = 3'd3,
    ST_SELECT     = 3'd4,
    ST_TRACK_SEED = 3'd5,
    ST_TRACK      = 3'd6
  } state_e;

  // x^7 + x^6 + 1: the oldest bit (r[6]) and the one after it (r[5]) feed back.
  localparam int PRBS_LEN   = 7;
  localparam int PRBS_TAP_A = 6;
  localparam int PRBS_TAP_B = 5;

  localparam int SEED_LEN = 7;

  function automatic logic prbs7_next(input logic [PRBS_LEN-1:0] r);
    return r[PRBS_TAP_A] ^ r[PRBS_TAP_B];
  endfunction

endpackage

// File: rtl/prbs7_chk.sv
// PRBS7 reference: self-synchronising load from the incoming stream, then
// free-running prediction compared against the incoming bit.
module prbs7_chk
  import prn_cdr_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_en,
  input  logic i_bit_in,
  output logic o_pred,
  output logic o_mismatch
);

  logic [PRBS_LEN-1:0] r_lfsr;
  logic                w_pred;

  assign w_pred = prbs7_next(r_lfsr);

  // r_lfsr[0] is the newest bit, r_lfsr[6] the oldest.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_lfsr <= '0;
    end else if (i_load) begin
      r_lfsr <= {r_lfsr[PRBS_LEN-2:0], i_bit_in};
    end else if (i_en) begin
      r_lfsr <= {r_lfsr[PRBS_LEN-2:0], w_pred};
    end
  end

  assign o_pred     = w_pred;
  assign o_mismatch = i_en & (w_pred ^ i_bit_in);

endmodule

// File: rtl/prn_phase_ctrl.sv
// Phase-selection controller for the PRN-based CDR: sweeps every sampling
// phase against a PRBS7 reference, selects the cleanest and keeps tracking it.
module prn_phase_ctrl
  import prn_cdr_pkg::*;
#(
  parameter int  N_PHASE       = 4,
  parameter int  WIN_LEN       = 256,
  parameter int  ERR_W         = 9,
  parameter int  LOCK_THRESH   = 2,
  parameter int  UNLOCK_THRESH = 8,
  localparam int PH_W          = $clog2(N_PHASE)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [N_PHASE-1:0] i_samp,
  output logic [PH_W-1:0]    o_phase_sel,
  output logic               o_lock,
  output logic               o_busy,
  output logic [ERR_W-1:0]   o_best_err,
  output logic               o_sweep_done,
  output logic               o_sweep_fail
);

  localparam int CNT_MAX = (WIN_LEN > SEED_LEN) ? WIN_LEN : SEED_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] SEED_LAST  = CNT_W'(SEED_LEN - 1);
  localparam logic [CNT_W-1:0] WIN_LAST   = CNT_W'(WIN_LEN - 1);
  localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(N_PHASE - 1);
  localparam logic [ERR_W-1:0] LOCK_LIM   = ERR_W'(LOCK_THRESH);
  localparam logic [ERR_W-1:0] UNLOCK_LIM = ERR_W'(UNLOCK_THRESH);
  localparam logic [ERR_W-1:0] ERR_MAX    = '1;

  state_e           r_state;
  logic [PH_W-1:0]  r_cur;
  logic [PH_W-1:0]  r_best_ph;
  logic [ERR_W-1:0] r_best_err_int;
  logic [ERR_W-1:0] r_err;
  logic [CNT_W-1:0] r_cnt;
  logic [PH_W-1:0]  r_phase_sel;
  logic             r_lock;
  logic [ERR_W-1:0] r_best_err;
  logic             r_sweep_done;
  logic             r_sweep_fail;

  logic             w_bit;
  logic             w_load;
  logic             w_en;
  logic             w_pred;
  logic             w_mismatch;
  logic [ERR_W-1:0] w_err_inc;
  logic             w_unused_pred;

  // During tracking r_cur mirrors phase_sel, so one mux serves both modes.
  assign w_bit  = i_samp[r_cur];
  assign w_load = (r_state == ST_SEED) || (r_state == ST_TRACK_SEED);
  assign w_en   = (r_state == ST_MEASURE) || (r_state == ST_TRACK);

  prbs7_chk u_chk (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_load),
    .i_en       (w_en),
    .i_bit_in   (w_bit),
    .o_pred     (w_pred),
    .o_mismatch (w_mismatch)
  );

  assign w_unused_pred = w_pred;

  assign w_err_inc = (w_mismatch && (r_err != ERR_MAX)) ? r_err + ERR_W'(1) : r_err;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state        <= ST_IDLE;
      r_cur          <= '0;
      r_best_ph      <= '0;
      r_best_err_int <= '1;
      r_err          <= '0;
      r_cnt          <= '0;
      r_phase_sel    <= '0;
      r_lock         <= 1'b0;
      r_best_err     <= '0;
      r_sweep_done   <= 1'b0;
      r_sweep_fail   <= 1'b0;
    end else begin
      r_sweep_done <= 1'b0;
      r_sweep_fail <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state        <= ST_SEED;
            r_cur          <= '0;
            r_best_ph      <= '0;
            r_best_err_int <= '1;
            r_err          <= '0;
            r_cnt          <= '0;
          end
        end

        ST_SEED, ST_TRACK_SEED: begin
          r_err <= '0;
          if (r_cnt == SEED_LAST) begin
            r_cnt   <= '0;
            r_state <= (r_state == ST_SEED) ? ST_MEASURE : ST_TRACK;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        ST_MEASURE: begin
          r_err <= w_err_inc;
          if (r_cnt == WIN_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_EVAL;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        ST_EVAL: begin
          // Strict compare: on a tie the earlier (lower) phase wins.
          if (r_err < r_best_err_int) begin
            r_best_err_int <= r_err;
            r_best_ph      <= r_cur;
          end
          if (r_cur == PH_LAST) begin
            r_state <= ST_SELECT;
          end else begin
            r_cur   <= r_cur + PH_W'(1);
            r_state <= ST_SEED;
          end
        end

        ST_SELECT: begin
          r_phase_sel  <= r_best_ph;
          r_best_err   <= r_best_err_int;
          r_sweep_done <= 1'b1;
          if (r_best_err_int <= LOCK_LIM) begin
            r_lock  <= 1'b1;
            r_cur   <= r_best_ph;
            r_state <= ST_TRACK_SEED;
          end else begin
            r_sweep_fail <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end

        ST_TRACK: begin
          if (r_cnt == WIN_LAST) begin
            r_cnt <= '0;
            r_err <= '0;
            if (w_err_inc > UNLOCK_LIM) begin
              r_lock         <= 1'b0;
              r_state        <= ST_SEED;
              r_cur          <= '0;
              r_best_ph      <= '0;
              r_best_err_int <= '1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_err <= w_err_inc;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_phase_sel  = r_phase_sel;
  assign o_lock       = r_lock;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_best_err   = r_best_err;
  assign o_sweep_done = r_sweep_done;
  assign o_sweep_fail = r_sweep_fail;

endmodule

// File: tb/tb_prn_phase_ctrl.sv
// Randomised bench for prn_phase_ctrl: every sampled bit is recorded and a
// sequence-level PRBS7 model recomputes window errors, choice, lock and timing.
module tb_prn_phase_ctrl;

  localparam int NP        = 4;
  localparam int WL        = 256;
  localparam int EW        = 9;
  localparam int LT        = 2;
  localparam int UT        = 8;
  localparam int PH_CYC    = 7 + WL + 1;
  localparam int SWEEP_CYC = NP * PH_CYC + 2;
  localparam int HIST_N    = 16384;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [NP-1:0] samp = '0;
  logic [1:0]    phase_sel;
  logic          lock;
  logic          busy;
  logic [EW-1:0] best_err;
  logic          sweep_done;
  logic          sweep_fail;

  always #5 clk = ~clk;

  prn_phase_ctrl #(
    .N_PHASE       (NP),
    .WIN_LEN       (WL),
    .ERR_W         (EW),
    .LOCK_THRESH   (LT),
    .UNLOCK_THRESH (UT)
  ) u_dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_samp       (samp),
    .o_phase_sel  (phase_sel),
    .o_lock       (lock),
    .o_busy       (busy),
    .o_best_err   (best_err),
    .o_sweep_done (sweep_done),
    .o_sweep_fail (sweep_fail)
  );

  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  int            last_done = 0;
  logic [NP-1:0] hist [HIST_N];
  bit            src_q [$];
  logic [NP-1:0] good_mask = '0;
  logic [NP-1:0] flip_mask = '0;
  bit            flip_set [WL];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: drive this cycle's samples, record them against the edge index.
  task automatic step();
    bit            b;
    logic [NP-1:0] v;
    b = src_q[0] ^ src_q[1];
    void'(src_q.pop_front());
    src_q.push_back(b);
    for (int i = 0; i < NP; i++)
      v[i] = good_mask[i] ? b : 1'($urandom_range(0, 1));
    v = v ^ flip_mask;
    samp = v;
    if (cyc < HIST_N) hist[cyc] = v;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Seeds a reference from 7 recorded bits, extends it by s[n]=s[n-7]^s[n-6]
  // and counts disagreements within the window [meas_at, meas_at+len).
  function automatic int count_err(input int ph, input int seed_at, input int meas_at, input int len);
    bit s [$];
    bit p;
    int e;
    e = 0;
    for (int k = 0; k < 7; k++) s.push_back(hist[seed_at + k][ph]);
    for (int n = seed_at + 7; n < meas_at + len; n++) begin
      p = s[s.size() - 7] ^ s[s.size() - 6];
      s.push_back(p);
      if (n >= meas_at && p != hist[n][ph] && e < (1 << EW) - 1) e++;
    end
    return e;
  endfunction

  task automatic pulse_start(output int e0);
    start = 1'b1;
    step();
    e0 = cyc - 1;
    start = 1'b0;
  endtask

  // Waits for sweep_done after a sweep that began at edge e0, then checks it.
  task automatic check_sweep(input string tag, input int e0, input int poke_off);
    int d;
    bit seen;
    int bph;
    int berr;
    int e;
    seen = 0;
    d = -1;
    for (int k = 0; k < SWEEP_CYC + 50 && !seen; k++) begin
      start = (poke_off > 0) && (cyc == e0 + poke_off);
      step();
      start = 1'b0;
      if (sweep_done === 1'b1) begin
        seen = 1;
        d = cyc - 1;
      end
    end
    if (!seen) begin
      check_eq({tag, " done_seen"}, 32'(0), 32'(1));
      return;
    end
    bph  = 0;
    berr = (1 << EW) - 1;
    for (int p = 0; p < NP; p++) begin
      e = count_err(p, e0 + 1 + p * PH_CYC, e0 + 8 + p * PH_CYC, WL);
      if (e < berr) begin
        berr = e;
        bph  = p;
      end
    end
    check_eq({tag, " latency"}, 32'(d - e0 + 1), 32'(SWEEP_CYC));
    check_eq({tag, " phase_sel"}, 32'(phase_sel), 32'(bph));
    check_eq({tag, " best_err"}, 32'(best_err), 32'(berr));
    check_eq({tag, " lock"}, 32'(lock), 32'(berr <= LT));
    check_eq({tag, " sweep_fail"}, 32'(sweep_fail), 32'(berr > LT));
    check_eq({tag, " busy"}, 32'(busy), 32'(berr <= LT));
    $display("sweep %s: start edge %0d done edge %0d phase_sel %0d best_err %0d lock %0d fail %0d",
             tag, e0, d, phase_sel, best_err, lock, sweep_fail);
    last_done = d;
  endtask

  task automatic track_window(input int ph, input int nflips);
    int            cnt;
    int            k;
    logic [NP-1:0] one_hot;
    one_hot = '0;
    one_hot[ph] = 1'b1;
    for (int i = 0; i < WL; i++) flip_set[i] = 1'b0;
    cnt = 0;
    while (cnt < nflips) begin
      k = $urandom_range(0, WL - 1);
      if (!flip_set[k]) begin
        flip_set[k] = 1'b1;
        cnt++;
      end
    end
    for (int i = 0; i < WL; i++) begin
      flip_mask = flip_set[i] ? one_hot : '0;
      step();
    end
    flip_mask = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0;
    int s_edge;
    int e;
    src_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    // Reset
    rst = 1'b0;
    repeat (3) step();
    check_eq("reset phase_sel", 32'(phase_sel), 32'(0));
    check_eq("reset lock", 32'(lock), 32'(0));
    check_eq("reset busy", 32'(busy), 32'(0));
    check_eq("reset best_err", 32'(best_err), 32'(0));
    check_eq("reset sweep_done", 32'(sweep_done), 32'(0));
    check_eq("reset sweep_fail", 32'(sweep_fail), 32'(0));
    rst = 1'b1;
    step();

    // Clean PRBS on phase 2 only
    good_mask = 4'b0100;
    pulse_start(e0);
    check_eq("best busy after start", 32'(busy), 32'(1));
    check_sweep("best_ph2", e0, 0);

    // Tracking: 8 errors keep lock, 9 errors drop it and re-sweep
    s_edge = last_done;
    repeat (7) step();
    track_window(2, 8);
    e = count_err(2, s_edge + 1, s_edge + 8, WL);
    check_eq("track8 lock", 32'(lock), 32'(e <= UT));
    check_eq("track8 busy", 32'(busy), 32'(1));
    track_window(2, 9);
    e = count_err(2, s_edge + 1, s_edge + 8 + WL, WL);
    check_eq("track9 lock", 32'(lock), 32'(e <= UT));
    check_eq("track9 busy", 32'(busy), 32'(1));
    check_eq("track9 phase_sel held", 32'(phase_sel), 32'(2));
    check_sweep("relock", s_edge + 7 + 2 * WL, 0);

    // Tie break between identical clean phases 1 and 3
    rst = 1'b0;
    step();
    check_eq("rst from track busy", 32'(busy), 32'(0));
    check_eq("rst from track lock", 32'(lock), 32'(0));
    rst = 1'b1;
    good_mask = 4'b1010;
    pulse_start(e0);
    check_sweep("tie_1_3", e0, 0);

    // No valid phase, with an ignored start pulse mid-sweep
    rst = 1'b0;
    step();
    rst = 1'b1;
    good_mask = 4'b0000;
    pulse_start(e0);
    check_sweep("no_valid", e0, 300);
    step();
    check_eq("no_valid idle busy", 32'(busy), 32'(0));
    check_eq("no_valid done pulse width", 32'(sweep_done), 32'(0));
    check_eq("no_valid fail pulse width", 32'(sweep_fail), 32'(0));

    // Reset during MEASURE of phase 2, then a full fresh sweep
    good_mask = 4'b1000;
    pulse_start(e0);
    while (cyc < e0 + 2 * PH_CYC + 8 + 50) step();
    check_eq("midsweep busy", 32'(busy), 32'(1));
    rst = 1'b0;
    step();
    rst = 1'b1;
    check_eq("midsweep rst busy", 32'(busy), 32'(0));
    check_eq("midsweep rst phase_sel", 32'(phase_sel), 32'(0));
    check_eq("midsweep rst best_err", 32'(best_err), 32'(0));
    check_eq("midsweep rst lock", 32'(lock), 32'(0));
    step();
    pulse_start(e0);
    check_sweep("after_reset", e0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
